// File: rtl/serial_word_tx.sv
// serial_word_tx: loads a WIDTH-bit word over valid/ready and shifts it out LSB first,
// framed by a frame_start pulse and a done pulse. Define SERIAL_WORD_TX_PARITY_EN to append an even-parity bit.
module serial_word_tx #(
  parameter int WIDTH = 5,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             frame_start,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam int LastIdx = WIDTH;
`else
  localparam int LastIdx = WIDTH - 1;
`endif
  localparam int CntW = $clog2(WIDTH + 2);
  localparam int GapW = 3;
  localparam logic [CntW-1:0] CntLast = CntW'(LastIdx);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP > 0) ? GAP - 1 : 0);
`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam logic [CntW-1:0] CntDataLast = CntW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    SEND     = 2'd2,
    GAP_WAIT = 2'd3
  } state_t;

  state_t           r_state, w_nextState;
  logic [WIDTH-1:0] r_shReg, w_shRegNext;
  logic [CntW-1:0]  r_bitCnt, w_bitCntNext;
  logic [GapW-1:0]  r_gapCnt, w_gapCntNext;
  logic             r_frameStart, w_frameStartNext;
  logic             r_serOut, w_serOutNext;
  logic             r_serValid, w_serValidNext;
  logic             r_done, w_doneNext;
`ifdef SERIAL_WORD_TX_PARITY_EN
  logic             r_parity, w_parityNext;
`endif

  // Output flops are loaded with the values for the state being entered, so each
  // registered output lines up with the cycle its state is occupied.
  always_comb begin
    w_nextState      = r_state;
    w_shRegNext      = r_shReg;
    w_bitCntNext     = r_bitCnt;
    w_gapCntNext     = r_gapCnt;
    w_frameStartNext = 1'b0;
    w_serOutNext     = 1'b0;
    w_serValidNext   = 1'b0;
    w_doneNext       = 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
    w_parityNext     = r_parity;
`endif
    case (r_state)
      IDLE: begin
        if (load_valid) begin
          w_nextState      = START;
          w_shRegNext      = data_in;
          w_frameStartNext = 1'b1;
`ifdef SERIAL_WORD_TX_PARITY_EN
          w_parityNext     = ^data_in;
`endif
        end
      end
      START: begin
        w_nextState    = SEND;
        w_serValidNext = 1'b1;
        w_serOutNext   = r_shReg[0];
        w_shRegNext    = r_shReg >> 1;
        w_bitCntNext   = '0;
      end
      SEND: begin
        if (r_bitCnt == CntLast) begin
          w_gapCntNext = '0;
          if (GAP > 0) w_nextState = GAP_WAIT;
          else         w_nextState = IDLE;
        end else begin
          w_bitCntNext   = r_bitCnt + 1'b1;
          w_serValidNext = 1'b1;
          w_serOutNext   = r_shReg[0];
`ifdef SERIAL_WORD_TX_PARITY_EN
          if (r_bitCnt == CntDataLast) w_serOutNext = r_parity;
`endif
          w_shRegNext    = r_shReg >> 1;
          w_doneNext     = (w_bitCntNext == CntLast);
        end
      end
      GAP_WAIT: begin
        if (r_gapCnt == GapLast) w_nextState = IDLE;
        else                     w_gapCntNext = r_gapCnt + 1'b1;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_shReg      <= '0;
      r_bitCnt     <= '0;
      r_gapCnt     <= '0;
      r_frameStart <= 1'b0;
      r_serOut     <= 1'b0;
      r_serValid   <= 1'b0;
      r_done       <= 1'b0;
`ifdef SERIAL_WORD_TX_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_state      <= w_nextState;
      r_shReg      <= w_shRegNext;
      r_bitCnt     <= w_bitCntNext;
      r_gapCnt     <= w_gapCntNext;
      r_frameStart <= w_frameStartNext;
      r_serOut     <= w_serOutNext;
      r_serValid   <= w_serValidNext;
      r_done       <= w_doneNext;
`ifdef SERIAL_WORD_TX_PARITY_EN
      r_parity     <= w_parityNext;
`endif
    end
  end

  assign load_ready  = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign frame_start = r_frameStart;
  assign ser_out     = r_serOut;
  assign ser_valid   = r_serValid;
  assign done        = r_done;

endmodule

// File: tb/tb_serial_word_tx.sv
// Self-checking bench for serial_word_tx: a WIDTH=5/GAP=1 instance driven from a vector table
// plus hand sequences, and a WIDTH=8/GAP=0 instance; serial bits are checked through scoreboards.
module tb_serial_word_tx;

`ifdef SERIAL_WORD_TX_PARITY_EN
  localparam bit ParityOn = 1'b1;
`else
  localparam bit ParityOn = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [4:0] dataIn;
  logic       loadValid, loadReady, frameStart, serOut, serValid, busy, done;
  logic [7:0] dataInB;
  logic       loadValidB, loadReadyB, frameStartB, serOutB, serValidB, busyB, doneB;

  int checks = 0;
  int fails  = 0;
  int framesA = 0;
  logic monOn = 1'b0;

  typedef struct {
    logic bitv;
    logic last;
  } expBit_t;

  expBit_t sbA[$];
  expBit_t sbB[$];

  typedef struct {
    logic [4:0] word;
    string      stream;
    logic       par;
  } vec_t;

  vec_t vecs[7];

  serial_word_tx #(.WIDTH(5), .GAP(1)) dut (
    .clk(clk), .reset(reset), .data_in(dataIn), .load_valid(loadValid),
    .load_ready(loadReady), .frame_start(frameStart), .ser_out(serOut),
    .ser_valid(serValid), .busy(busy), .done(done)
  );

  serial_word_tx #(.WIDTH(8), .GAP(0)) dutB (
    .clk(clk), .reset(reset), .data_in(dataInB), .load_valid(loadValidB),
    .load_ready(loadReadyB), .frame_start(frameStartB), .ser_out(serOutB),
    .ser_valid(serValidB), .busy(busyB), .done(doneB)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench goes through here so the counts stay in one place.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected streams are written in transmission order; the parity bit becomes the done bit when enabled.
  task automatic pushExp(input bit toB, input string s, input logic p);
    expBit_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.bitv = (s[i] == "1");
      e.last = !ParityOn && (i == s.len() - 1);
      if (toB) sbB.push_back(e);
      else     sbA.push_back(e);
    end
    if (ParityOn) begin
      e.bitv = p;
      e.last = 1'b1;
      if (toB) sbB.push_back(e);
      else     sbA.push_back(e);
    end
  endtask

  // Sample instance A on the falling edge: every valid bit must match the head of the scoreboard.
  always @(negedge clk) begin : monA
    expBit_t e;
    if (monOn) begin
      if (frameStart) framesA++;
      checkOutput("A busy vs load_ready", busy, !loadReady);
      if (serValid) begin
        if (sbA.size() == 0) checkOutput("A ser_valid with empty scoreboard", serValid, 0);
        else begin
          e = sbA.pop_front();
          checkOutput("A ser_out", serOut, e.bitv);
          checkOutput("A done", done, e.last);
        end
      end else begin
        checkOutput("A idle ser_out/done", {serOut, done}, 2'b00);
      end
    end
  end

  // Same checks for instance B.
  always @(negedge clk) begin : monB
    expBit_t e;
    if (monOn) begin
      checkOutput("B busy vs load_ready", busyB, !loadReadyB);
      if (serValidB) begin
        if (sbB.size() == 0) checkOutput("B ser_valid with empty scoreboard", serValidB, 0);
        else begin
          e = sbB.pop_front();
          checkOutput("B ser_out", serOutB, e.bitv);
          checkOutput("B done", doneB, e.last);
        end
      end else begin
        checkOutput("B idle ser_out/done", {serOutB, doneB}, 2'b00);
      end
    end
  end

  // Called just after a rising edge; returns just after the transfer edge (START cycle).
  task automatic applyStimulus(input logic [4:0] w, input string s, input logic p);
    int n = 0;
    while (!loadReady && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("A load_ready before load", loadReady, 1);
    dataIn    = w;
    loadValid = 1'b1;
    @(posedge clk);
    pushExp(1'b0, s, p);
    #1;
    loadValid = 1'b0;
    dataIn    = 5'($urandom);
    checkOutput("A frame_start after transfer", frameStart, 1);
    checkOutput("A ser_valid low in START", serValid, 0);
  endtask

  task automatic waitIdleA();
    int n = 0;
    while (!(loadReady && sbA.size() == 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("A idle with scoreboard drained", {loadReady, sbA.size() == 0}, 2'b11);
  endtask

  task automatic waitDoneA();
    int n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("A done pulse reached", done, 1);
  endtask

  task automatic setVec(input int idx, input logic [4:0] w, input string s, input logic p);
    vecs[idx].word   = w;
    vecs[idx].stream = s;
    vecs[idx].par    = p;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not reach the end, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int f0;
    clk        = 1'b0;
    reset      = 1'b1;
    loadValid  = 1'b0;
    dataIn     = '0;
    loadValidB = 1'b0;
    dataInB    = '0;
    #1 reset = 1'b0;
    #1;
    checkOutput("reset load_ready", loadReady, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset frame_start", frameStart, 0);
    checkOutput("reset ser_out", serOut, 0);
    checkOutput("reset ser_valid", serValid, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset B load_ready", loadReadyB, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    monOn = 1'b1;

    // Single frame with done / load_ready timing around the gap cycle.
    applyStimulus(5'b10110, "01101", 1'b1);
    waitDoneA();
    checkOutput("T1 load_ready low at done", loadReady, 0);
    @(posedge clk); #1;
    checkOutput("T1 gap cycle busy/ready/valid", {busy, loadReady, serValid}, 3'b100);
    @(posedge clk); #1;
    checkOutput("T1 load_ready back two cycles after done", loadReady, 1);
    waitIdleA();

    // Vector table, including the parity corner words.
    setVec(0, 5'b10110, "01101", 1'b1);
    setVec(1, 5'b00001, "10000", 1'b1);
    setVec(2, 5'b11111, "11111", 1'b1);
    setVec(3, 5'b01010, "01010", 1'b0);
    setVec(4, 5'b11011, "11011", 1'b0);
    setVec(5, 5'b00110, "01100", 1'b0);
    setVec(6, 5'b00011, "11000", 1'b0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].word, vecs[i].stream, vecs[i].par);
      waitIdleA();
    end

    // Back-to-back with load_valid held high.
    dataIn    = 5'b00001;
    loadValid = 1'b1;
    @(posedge clk);
    pushExp(1'b0, "10000", 1'b1);
    #1;
    dataIn = 5'b11111;
    checkOutput("B2B first frame_start", frameStart, 1);
    waitDoneA();
    @(posedge clk); #1;
    checkOutput("B2B gap cycle load_ready", loadReady, 0);
    @(posedge clk); #1;
    checkOutput("B2B idle cycle load_ready", loadReady, 1);
    @(posedge clk);
    pushExp(1'b0, "11111", 1'b1);
    #1;
    loadValid = 1'b0;
    checkOutput("B2B second frame_start", frameStart, 1);
    waitIdleA();

    // Handshake stall: a valid pulse while busy must be dropped.
    applyStimulus(5'b11111, "11111", 1'b1);
    @(posedge clk); #1;
    checkOutput("stall busy during frame", busy, 1);
    f0        = framesA;
    dataIn    = 5'b01010;
    loadValid = 1'b1;
    @(posedge clk); #1;
    loadValid = 1'b0;
    waitIdleA();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall no extra frame", framesA - f0, 0);
    applyStimulus(5'b01010, "01010", 1'b0);
    waitIdleA();
    checkOutput("stall exactly one later frame", framesA - f0, 1);

    // Reset while the third bit is on the line.
    applyStimulus(5'b11011, "11011", 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    checkOutput("mid-frame ser_valid before reset", serValid, 1);
    reset = 1'b0;
    #1;
    checkOutput("async reset ser_valid", serValid, 0);
    checkOutput("async reset ser_out", serOut, 0);
    checkOutput("async reset done", done, 0);
    checkOutput("async reset busy", busy, 0);
    sbA.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput("post-reset load_ready", loadReady, 1);
    applyStimulus(5'b00110, "01100", 1'b0);
    waitIdleA();

    // WIDTH=8, GAP=0 instance.
    checkOutput("W8 load_ready before load", loadReadyB, 1);
    dataInB    = 8'hA5;
    loadValidB = 1'b1;
    @(posedge clk);
    pushExp(1'b1, "10100101", 1'b0);
    #1;
    loadValidB = 1'b0;
    checkOutput("W8 frame_start", frameStartB, 1);
    begin
      int n = 0;
      while (!doneB && n < 50) begin
        @(posedge clk); #1; n++;
      end
    end
    checkOutput("W8 done pulse reached", doneB, 1);
    checkOutput("W8 load_ready low at done", loadReadyB, 0);
    @(posedge clk); #1;
    checkOutput("W8 load_ready cycle after done", loadReadyB, 1);
    checkOutput("W8 scoreboard drained", sbB.size(), 0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("A scoreboard empty at end", sbA.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
